// File: rtl/mem_stage_oq.sv
// ----------------------------------------------------------------------------
// mem_stage_oq
//
// MEM pipeline stage built around an in-order queue of instructions whose
// data-SRAM reads may still be in flight. EX can keep issuing loads before
// earlier responses return. Load data is aligned and extended here. The oldest
// completed instruction is presented to WB. After an exception flush, the
// responses that belong to cancelled requests are counted down and discarded.
//
// Handshakes (valid/ready):
//   EX -> MS : an instruction transfers on a rising edge when
//              es_to_ms_valid & ms_allowin. ms_allowin never depends on
//              es_to_ms_valid.
//   MS -> WB : the head transfers on a rising edge when
//              ms_to_ws_valid & ws_allowin. While ws_allowin is low the head
//              outputs hold stable.
//   SRAM     : EX may issue a new request only while ms_req_allow is high.
//              data_sram_data_ok returns responses in request order.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   es_to_ms_valid / ms_allowin       EX handshake
//   es_req / ms_req_allow             request pending flag / request credit
//   es_ld_op, es_res_from_mem,        load kind (0 none, 1 b, 2 bu, 3 h,
//   es_rf_we, es_rf_waddr,            4 hu, 5 w, 6 wu, 7 d), writeback
//   es_result, es_pc, es_except       controls and payload from EX
//   ws_allowin / ms_to_ws_valid       WB handshake
//   ms_pc, ms_rf_we, ms_rf_waddr,     head-entry fields (zero when empty)
//   ms_rf_wdata, ms_except
//   data_sram_data_ok, _rdata         in-order read responses
//   except_flush                      discard every queued entry
//   ms_busy                           entries valid or cancelled reads pending
// ----------------------------------------------------------------------------
module mem_stage_oq #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int EXC_W  = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic              es_req,
    output logic              ms_req_allow,
    input  logic [2:0]        es_ld_op,
    input  logic              es_res_from_mem,
    input  logic              es_rf_we,
    input  logic [4:0]        es_rf_waddr,
    input  logic [DATA_W-1:0] es_result,
    input  logic [31:0]       es_pc,
    input  logic [EXC_W-1:0]  es_except,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic              ms_rf_we,
    output logic [4:0]        ms_rf_waddr,
    output logic [DATA_W-1:0] ms_rf_wdata,
    output logic [EXC_W-1:0]  ms_except,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              except_flush,
    output logic              ms_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFF_W = $clog2(DATA_W / 8);

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    logic              r_valid  [DEPTH];
    logic [31:0]       r_pc     [DEPTH];
    logic [2:0]        r_ld_op  [DEPTH];
    logic              r_res_mem[DEPTH];
    logic              r_rf_we  [DEPTH];
    logic [4:0]        r_waddr  [DEPTH];
    logic [DATA_W-1:0] r_result [DEPTH];
    logic [EXC_W-1:0]  r_except [DEPTH];
    logic              r_req    [DEPTH];
    logic              r_filled [DEPTH];
    logic [DATA_W-1:0] r_rdata  [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_cancel;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  w_unfilled;
    logic              w_tgt_found;
    logic [PTR_W-1:0]  w_tgt_idx;
    logic [CNT_W:0]    w_outstanding;
    logic [CNT_W:0]    w_cancel_flush;
    logic              w_fill;
    logic              w_head_valid;
    logic              w_head_bypass;
    logic              w_head_done;
    logic              w_pop;
    logic              w_push;
    logic [DATA_W-1:0] w_head_rdata;
    logic [OFF_W-1:0]  w_off;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_extract;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Count unfilled requests and find the oldest one. Responses come back in
    // request order, so the oldest unfilled entry (walking from head) is the
    // one the next non-cancelled data_ok belongs to.
    always_comb begin
        int idx;
        w_unfilled  = '0;
        w_tgt_found = 1'b0;
        w_tgt_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_req[i] && !r_filled[i]) begin
                w_unfilled = w_unfilled + CNT_W'(1);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = int'(r_head) + i;
            if (idx >= DEPTH) begin
                idx = idx - DEPTH;
            end
            if (!w_tgt_found && r_valid[idx] && r_req[idx] && !r_filled[idx]) begin
                w_tgt_found = 1'b1;
                w_tgt_idx   = PTR_W'(idx);
            end
        end
    end

    assign w_outstanding = {1'b0, w_unfilled} + {1'b0, r_cancel};
    assign ms_req_allow  = (w_outstanding < (CNT_W + 1)'(DEPTH));

    // On flush every unfilled request becomes a cancelled one; a response
    // arriving in the flush cycle retires one of them immediately.
    always_comb begin
        w_cancel_flush = w_outstanding;
        if (data_sram_data_ok && (w_outstanding != '0)) begin
            w_cancel_flush = w_outstanding - (CNT_W + 1)'(1);
        end
    end

    assign w_fill        = data_sram_data_ok && (r_cancel == '0) && w_tgt_found;
    assign w_head_valid  = r_valid[r_head];
    assign w_head_bypass = w_fill && (w_tgt_idx == r_head);
    assign w_head_done   = !r_req[r_head] || r_filled[r_head] || w_head_bypass;

    assign ms_to_ws_valid = w_head_valid && w_head_done && !except_flush;
    assign w_pop          = ms_to_ws_valid && ws_allowin;
    assign ms_allowin     = (r_count < CNT_W'(DEPTH)) || w_pop;
    assign w_push         = es_to_ms_valid && ms_allowin && !except_flush;

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    assign w_head_rdata = w_head_bypass ? data_sram_rdata : r_rdata[r_head];
    assign w_off        = r_result[r_head][OFF_W-1:0];
    assign w_shift      = w_head_rdata >> {w_off, 3'b000};

    // With a 32-bit datapath, wu and d fall back to a plain signed word.
    always_comb begin
        w_extract = w_shift;
        case (r_ld_op[r_head])
            3'd1: w_extract = DATA_W'($signed(w_shift[7:0]));
            3'd2: w_extract = DATA_W'(w_shift[7:0]);
            3'd3: w_extract = DATA_W'($signed(w_shift[15:0]));
            3'd4: w_extract = DATA_W'(w_shift[15:0]);
            3'd5: w_extract = DATA_W'($signed(w_shift[31:0]));
            3'd6: begin
                if (DATA_W == 64) begin
                    w_extract = DATA_W'(w_shift[31:0]);
                end else begin
                    w_extract = DATA_W'($signed(w_shift[31:0]));
                end
            end
            3'd7: begin
                if (DATA_W == 64) begin
                    w_extract = w_shift;
                end else begin
                    w_extract = DATA_W'($signed(w_shift[31:0]));
                end
            end
            default: w_extract = w_shift;
        endcase
    end

    // Head fields read as zero while the queue is empty.
    assign ms_pc       = w_head_valid ? r_pc[r_head]     : '0;
    assign ms_rf_we    = w_head_valid && r_rf_we[r_head];
    assign ms_rf_waddr = w_head_valid ? r_waddr[r_head]  : '0;
    assign ms_except   = w_head_valid ? r_except[r_head] : '0;
    assign ms_rf_wdata = !w_head_valid     ? '0 :
                         r_res_mem[r_head] ? w_extract : r_result[r_head];

    assign ms_busy = (r_count != '0) || (r_cancel != '0);

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_cancel <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_pc[i]      <= '0;
                r_ld_op[i]   <= '0;
                r_res_mem[i] <= 1'b0;
                r_rf_we[i]   <= 1'b0;
                r_waddr[i]   <= '0;
                r_result[i]  <= '0;
                r_except[i]  <= '0;
                r_req[i]     <= 1'b0;
                r_filled[i]  <= 1'b0;
                r_rdata[i]   <= '0;
            end
        end else if (except_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_cancel <= CNT_W'(w_cancel_flush);
        end else begin
            if (data_sram_data_ok && (r_cancel != '0)) begin
                r_cancel <= r_cancel - CNT_W'(1);
            end
            // An entry filled and retired in the same cycle is not written.
            if (w_fill && !(w_pop && w_head_bypass)) begin
                r_filled[w_tgt_idx] <= 1'b1;
                r_rdata[w_tgt_idx]  <= data_sram_rdata;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= next_ptr(r_head);
            end
            // Placed after pop so a full-queue push into the slot being
            // retired leaves it valid.
            if (w_push) begin
                r_valid[r_tail]   <= 1'b1;
                r_pc[r_tail]      <= es_pc;
                r_ld_op[r_tail]   <= es_ld_op;
                r_res_mem[r_tail] <= es_res_from_mem;
                r_rf_we[r_tail]   <= es_rf_we;
                r_waddr[r_tail]   <= es_rf_waddr;
                r_result[r_tail]  <= es_result;
                r_except[r_tail]  <= es_except;
                r_req[r_tail]     <= es_req;
                r_filled[r_tail]  <= 1'b0;
                r_tail            <= next_ptr(r_tail);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_mem_stage_oq.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_oq
//
// Directed bench for mem_stage_oq. Instance a uses DATA_W=32/DEPTH=2 and
// instance b uses DATA_W=64/DEPTH=2. Inputs change 1 ns after the rising
// edge, and outputs are sampled 1 ns after that.
// ----------------------------------------------------------------------------
module tb_mem_stage_oq;

    logic clk;
    logic resetn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance a (32-bit) ----------------
    logic        a_es_valid, a_allowin, a_es_req, a_req_allow;
    logic [2:0]  a_ld_op;
    logic        a_res_mem, a_rf_we_in;
    logic [4:0]  a_waddr_in;
    logic [31:0] a_result, a_pc_in;
    logic [6:0]  a_exc_in;
    logic        a_ws_allowin, a_valid;
    logic [31:0] a_pc;
    logic        a_rf_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [6:0]  a_exc;
    logic        a_data_ok;
    logic [31:0] a_rdata;
    logic        a_flush, a_busy;

    mem_stage_oq #(.DATA_W(32), .DEPTH(2), .EXC_W(7)) dut_a (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(a_es_valid), .ms_allowin(a_allowin),
        .es_req(a_es_req), .ms_req_allow(a_req_allow),
        .es_ld_op(a_ld_op), .es_res_from_mem(a_res_mem), .es_rf_we(a_rf_we_in),
        .es_rf_waddr(a_waddr_in), .es_result(a_result), .es_pc(a_pc_in),
        .es_except(a_exc_in), .ws_allowin(a_ws_allowin),
        .ms_to_ws_valid(a_valid), .ms_pc(a_pc), .ms_rf_we(a_rf_we),
        .ms_rf_waddr(a_waddr), .ms_rf_wdata(a_wdata), .ms_except(a_exc),
        .data_sram_data_ok(a_data_ok), .data_sram_rdata(a_rdata),
        .except_flush(a_flush), .ms_busy(a_busy)
    );

    // ---------------- instance b (64-bit) ----------------
    logic        b_es_valid, b_allowin, b_es_req, b_req_allow;
    logic [2:0]  b_ld_op;
    logic        b_res_mem, b_rf_we_in;
    logic [4:0]  b_waddr_in;
    logic [63:0] b_result;
    logic [31:0] b_pc_in;
    logic [6:0]  b_exc_in;
    logic        b_ws_allowin, b_valid;
    logic [31:0] b_pc;
    logic        b_rf_we;
    logic [4:0]  b_waddr;
    logic [63:0] b_wdata;
    logic [6:0]  b_exc;
    logic        b_data_ok;
    logic [63:0] b_rdata;
    logic        b_flush, b_busy;

    mem_stage_oq #(.DATA_W(64), .DEPTH(2), .EXC_W(7)) dut_b (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(b_es_valid), .ms_allowin(b_allowin),
        .es_req(b_es_req), .ms_req_allow(b_req_allow),
        .es_ld_op(b_ld_op), .es_res_from_mem(b_res_mem), .es_rf_we(b_rf_we_in),
        .es_rf_waddr(b_waddr_in), .es_result(b_result), .es_pc(b_pc_in),
        .es_except(b_exc_in), .ws_allowin(b_ws_allowin),
        .ms_to_ws_valid(b_valid), .ms_pc(b_pc), .ms_rf_we(b_rf_we),
        .ms_rf_waddr(b_waddr), .ms_rf_wdata(b_wdata), .ms_except(b_exc),
        .data_sram_data_ok(b_data_ok), .data_sram_rdata(b_rdata),
        .except_flush(b_flush), .ms_busy(b_busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_es_valid = 1'b0; a_es_req = 1'b0; a_ld_op = 3'd0; a_res_mem = 1'b0;
        a_rf_we_in = 1'b0; a_waddr_in = 5'd0; a_result = 32'd0; a_pc_in = 32'd0;
        a_exc_in = 7'd0;
    endtask

    task automatic clear_b();
        b_es_valid = 1'b0; b_es_req = 1'b0; b_ld_op = 3'd0; b_res_mem = 1'b0;
        b_rf_we_in = 1'b0; b_waddr_in = 5'd0; b_result = 64'd0; b_pc_in = 32'd0;
        b_exc_in = 7'd0;
    endtask

    task automatic push_a(input logic [2:0] op, input logic req, input logic res_mem,
                          input logic [4:0] waddr, input logic [31:0] result);
        a_es_valid = 1'b1; a_es_req = req; a_ld_op = op; a_res_mem = res_mem;
        a_rf_we_in = 1'b1; a_waddr_in = waddr; a_result = result;
        a_pc_in = 32'h1c00_0000 + result; a_exc_in = 7'd0;
    endtask

    // Single load on instance a: push, see it wait, then complete via bypass.
    task automatic load_a(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
        push_a(op, 1'b1, 1'b1, 5'd5, addr);
        tick();
        clear_a();
        #1;
        chk({tag, "_wait"}, a_valid, 1'b0);
        a_data_ok = 1'b1; a_rdata = rdata;
        #1;
        chk({tag, "_valid"}, a_valid, 1'b1);
        chk({tag, "_wdata"}, a_wdata, exp);
        tick();
        a_data_ok = 1'b0;
    endtask

    task automatic load_b(input string tag, input logic [2:0] op, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
        b_es_valid = 1'b1; b_es_req = 1'b1; b_ld_op = op; b_res_mem = 1'b1;
        b_rf_we_in = 1'b1; b_waddr_in = 5'd9; b_result = addr; b_pc_in = 32'h2000;
        tick();
        clear_b();
        #1;
        chk({tag, "_wait"}, b_valid, 1'b0);
        b_data_ok = 1'b1; b_rdata = rdata;
        #1;
        chk({tag, "_valid"}, b_valid, 1'b1);
        chk({tag, "_wdata"}, b_wdata, exp);
        tick();
        b_data_ok = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn = 1'b0;
        clear_a(); clear_b();
        a_ws_allowin = 1'b1; a_data_ok = 1'b0; a_rdata = '0; a_flush = 1'b0;
        b_ws_allowin = 1'b1; b_data_ok = 1'b0; b_rdata = '0; b_flush = 1'b0;

        // Reset values
        #3;
        chk("rst_allowin", a_allowin, 1'b1);
        chk("rst_req_allow", a_req_allow, 1'b1);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_rf_we", a_rf_we, 1'b0);
        chk("rst_b_req_allow", b_req_allow, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Non-load flow: visible the cycle after the push
        push_a(3'd0, 1'b0, 1'b0, 5'd3, 32'h1234);
        #1;
        chk("nl_allowin", a_allowin, 1'b1);
        tick();
        clear_a();
        #1;
        chk("nl_valid", a_valid, 1'b1);
        chk("nl_wdata", a_wdata, 32'h1234);
        chk("nl_rf_we", a_rf_we, 1'b1);
        chk("nl_waddr", a_waddr, 5'd3);
        chk("nl_pc", a_pc, 32'h1c00_1234);
        tick();
        chk("nl_empty_valid", a_valid, 1'b0);
        chk("nl_empty_busy", a_busy, 1'b0);
        chk("nl_empty_rf_we", a_rf_we, 1'b0);

        // Alignment and extension
        load_a("ld_b",  3'd1, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
        load_a("ld_bu", 3'd2, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
        load_a("ld_hu", 3'd4, 32'h0000_1002, 32'h80FF_0000, 32'h0000_80FF);
        load_a("ld_h",  3'd3, 32'h0000_1002, 32'h80FF_0000, 32'hFFFF_80FF);
        load_a("ld_w",  3'd5, 32'h0000_1000, 32'h80FF_0000, 32'h80FF_0000);

        // Pipelined loads, responses in order
        push_a(3'd5, 1'b1, 1'b1, 5'd1, 32'h2000);
        #1;
        chk("pipe_ra0", a_req_allow, 1'b1);
        tick();
        push_a(3'd5, 1'b1, 1'b1, 5'd2, 32'h2004);
        #1;
        chk("pipe_ra1", a_req_allow, 1'b1);
        tick();
        clear_a();
        #1;
        chk("pipe_ra2", a_req_allow, 1'b0);
        chk("pipe_full", a_allowin, 1'b0);
        chk("pipe_wait", a_valid, 1'b0);
        exp_q.push_back(32'hA);
        exp_q.push_back(32'hB);
        a_data_ok = 1'b1; a_rdata = 32'hA;
        #1;
        chk("pipe_v0", a_valid, 1'b1);
        chk("pipe_d0", a_wdata, exp_q.pop_front());
        chk("pipe_a0", a_waddr, 5'd1);
        tick();
        a_rdata = 32'hB;
        #1;
        chk("pipe_ra3", a_req_allow, 1'b1);
        chk("pipe_v1", a_valid, 1'b1);
        chk("pipe_d1", a_wdata, exp_q.pop_front());
        chk("pipe_a1", a_waddr, 5'd2);
        tick();
        a_data_ok = 1'b0;
        #1;
        chk("pipe_idle", a_busy, 1'b0);
        chk("pipe_q", exp_q.size(), 0);

        // WB stall across the response
        push_a(3'd5, 1'b1, 1'b1, 5'd7, 32'h3000);
        tick();
        clear_a();
        a_ws_allowin = 1'b0; a_data_ok = 1'b1; a_rdata = 32'h1122_3344;
        #1;
        chk("stall_v0", a_valid, 1'b1);
        chk("stall_d0", a_wdata, 32'h1122_3344);
        tick();
        a_data_ok = 1'b0; a_rdata = 32'hDEAD_BEEF;
        #1;
        chk("stall_v1", a_valid, 1'b1);
        chk("stall_d1", a_wdata, 32'h1122_3344);
        chk("stall_a1", a_waddr, 5'd7);
        tick();
        chk("stall_v2", a_valid, 1'b1);
        chk("stall_d2", a_wdata, 32'h1122_3344);
        tick();
        a_ws_allowin = 1'b1;
        #1;
        chk("stall_v3", a_valid, 1'b1);
        chk("stall_d3", a_wdata, 32'h1122_3344);
        tick();
        chk("stall_done", a_valid, 1'b0);
        chk("stall_busy", a_busy, 1'b0);

        // Flush with two unfilled loads
        push_a(3'd5, 1'b1, 1'b1, 5'd4, 32'h4000);
        tick();
        push_a(3'd5, 1'b1, 1'b1, 5'd4, 32'h4004);
        tick();
        clear_a();
        a_flush = 1'b1;
        #1;
        chk("fl_valid", a_valid, 1'b0);
        chk("fl_busy", a_busy, 1'b1);
        tick();
        a_flush = 1'b0;
        #1;
        chk("fl_busy1", a_busy, 1'b1);
        chk("fl_valid1", a_valid, 1'b0);
        chk("fl_ra", a_req_allow, 1'b0);
        chk("fl_allowin", a_allowin, 1'b1);
        a_data_ok = 1'b1; a_rdata = 32'h55;
        #1;
        chk("fl_drop0", a_valid, 1'b0);
        tick();
        a_rdata = 32'h66;
        push_a(3'd5, 1'b1, 1'b1, 5'd6, 32'h4008);
        #1;
        chk("fl_ra1", a_req_allow, 1'b1);
        chk("fl_drop1", a_valid, 1'b0);
        tick();
        clear_a();
        a_rdata = 32'h77;
        #1;
        chk("fl_third_v", a_valid, 1'b1);
        chk("fl_third_d", a_wdata, 32'h77);
        chk("fl_third_a", a_waddr, 5'd6);
        tick();
        a_data_ok = 1'b0;
        #1;
        chk("fl_idle", a_busy, 1'b0);

        // Full queue: push and pop in the same cycle
        a_ws_allowin = 1'b0;
        push_a(3'd0, 1'b0, 1'b0, 5'd1, 32'h111);
        tick();
        push_a(3'd0, 1'b0, 1'b0, 5'd2, 32'h222);
        tick();
        push_a(3'd0, 1'b0, 1'b0, 5'd3, 32'h333);
        #1;
        chk("full_allowin0", a_allowin, 1'b0);
        chk("full_d0", a_wdata, 32'h111);
        a_ws_allowin = 1'b1;
        #1;
        chk("full_allowin1", a_allowin, 1'b1);
        tick();
        clear_a();
        #1;
        chk("full_d1", a_wdata, 32'h222);
        tick();
        chk("full_d2", a_wdata, 32'h333);
        chk("full_v2", a_valid, 1'b1);
        tick();
        chk("full_empty", a_valid, 1'b0);
        chk("full_busy", a_busy, 1'b0);

        // 64-bit datapath
        load_b("b_ld_d",  3'd7, 64'h5000, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
        load_b("b_ld_w",  3'd5, 64'h5004, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000);
        load_b("b_ld_wu", 3'd6, 64'h5004, 64'h8000_0000_0000_0001, 64'h0000_0000_8000_0000);
        load_b("b_ld_b",  3'd1, 64'h5007, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FF80);
        load_b("b_ld_h",  3'd3, 64'h5000, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001);
        #1;
        chk("b_idle", b_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
